// File: rtl/scramble_ctrl_pkg.sv
// Shared FFT pipeline definitions: default sizes and scrambler state encoding.
package scramble_ctrl_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int MEM_SIZE_DEF  = 32;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } scr_state_t;

  // Reference bit reversal, handy for assertions and benches.
  function automatic int unsigned bitrev_int(input int unsigned value, input int unsigned width);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < width; i++) begin
      result = (result << 1) | ((value >> i) & 1);
    end
    return result;
  endfunction

endpackage

// File: rtl/scramble_ctrl_bit_reverse.sv
// Combinational address bit reversal: output bit i is input bit ADDR_SIZE-1-i.
module bit_reverse #(
  parameter int ADDR_SIZE = 5
) (
  input  logic [ADDR_SIZE-1:0] addr_in,
  output logic [ADDR_SIZE-1:0] addr_rev
);

  // Mirror the address bits end for end.
  always_comb begin
    addr_rev = '0;
    for (int i = 0; i < ADDR_SIZE; i++) begin
      addr_rev[i] = addr_in[ADDR_SIZE-1-i];
    end
  end

endmodule

// File: rtl/scramble_ctrl.sv
// Input reorder stage for a radix-2 FFT: samples arrive in time order and are
// written at bit-reversed RAM addresses; the frame is then read out as
// adjacent (even, odd) address pairs for the first butterfly stage.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_LOAD  | accepting samples, writing RAM at bitrev(wr_cnt)
//   ST_DRAIN | presenting pairs (2*pair_cnt, 2*pair_cnt+1) downstream
module scramble_ctrl
  import scramble_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int MEM_SIZE  = MEM_SIZE_DEF,
  parameter int ADDR_SIZE = $clog2(MEM_SIZE)
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_in_valid,
  input  logic [WORD_SIZE-1:0] i_in_data,
  output logic                 o_in_ready,
  output logic                 o_out_valid,
  output logic [WORD_SIZE-1:0] o_out_data_A,
  output logic [WORD_SIZE-1:0] o_out_data_B,
  input  logic                 i_out_ready,
  output logic                 o_frame_done,
  output logic                 o_ram_write_en_A,
  output logic [ADDR_SIZE-1:0] o_ram_write_addr_A,
  output logic [WORD_SIZE-1:0] o_ram_write_data_A,
  output logic                 o_ram_read_en_A,
  output logic                 o_ram_read_en_B,
  output logic [ADDR_SIZE-1:0] o_ram_read_addr_A,
  output logic [ADDR_SIZE-1:0] o_ram_read_addr_B,
  input  logic [WORD_SIZE-1:0] i_ram_read_data_A,
  input  logic [WORD_SIZE-1:0] i_ram_read_data_B
);

  localparam int                   PAIR_SIZE = ADDR_SIZE - 1;
  localparam logic [ADDR_SIZE-1:0] WR_LAST   = ADDR_SIZE'(MEM_SIZE - 1);
  localparam logic [PAIR_SIZE-1:0] PAIR_LAST = PAIR_SIZE'(MEM_SIZE / 2 - 1);

  scr_state_t           state;
  logic [ADDR_SIZE-1:0] wr_cnt;
  logic [ADDR_SIZE-1:0] wr_addr_rev;
  logic [PAIR_SIZE-1:0] pair_cnt;

  logic in_load;
  logic in_drain;
  logic accept;
  logic consume;
  logic last_write;
  logic last_pair;

  bit_reverse #(
    .ADDR_SIZE (ADDR_SIZE)
  ) u_bit_reverse (
    .addr_in  (wr_cnt),
    .addr_rev (wr_addr_rev)
  );

  // Reset masks every output immediately, not just from the next edge.
  assign in_load    = !i_RST && (state == ST_LOAD);
  assign in_drain   = !i_RST && (state == ST_DRAIN);
  assign accept     = in_load && i_in_valid;
  assign consume    = in_drain && i_out_ready;
  assign last_write = (wr_cnt == WR_LAST);
  assign last_pair  = (pair_cnt == PAIR_LAST);

  // Output decode from current state; read data passes straight through.
  always_comb begin
    o_in_ready         = in_load;
    o_ram_write_en_A   = accept;
    o_ram_write_addr_A = accept ? wr_addr_rev : '0;
    o_ram_write_data_A = accept ? i_in_data : '0;

    o_ram_read_en_A    = in_drain;
    o_ram_read_en_B    = in_drain;
    o_ram_read_addr_A  = in_drain ? {pair_cnt, 1'b0} : '0;
    o_ram_read_addr_B  = in_drain ? {pair_cnt, 1'b1} : '0;

    o_out_valid        = in_drain;
    o_out_data_A       = in_drain ? i_ram_read_data_A : '0;
    o_out_data_B       = in_drain ? i_ram_read_data_B : '0;
    o_frame_done       = consume && last_pair;
  end

  // State and frame counters; counters only wrap at frame boundaries.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state    <= ST_LOAD;
      wr_cnt   <= '0;
      pair_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (last_write) begin
              wr_cnt <= '0;
              state  <= ST_DRAIN;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (consume) begin
            if (last_pair) begin
              pair_cnt <= '0;
              state    <= ST_LOAD;
            end else begin
              pair_cnt <= pair_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_LOAD;
          wr_cnt   <= '0;
          pair_cnt <= '0;
        end
      endcase
    end
  end

endmodule
